// File: rtl/frame_receiver_with_sync.sv
// ---------------------------------------------------------------------------
// frame_receiver_with_sync
//
// Receive side of a 10-bit sync-framed byte link. Each link word carries
// {stop(1), data[7:0], start(0)}. The block checks the framing bits, strips
// them, and assembles FRAME_BYTES consecutive good bytes into one frame.
// Framing errors and inter-word gap timeouts abort the partial frame and are
// counted in a saturating error counter.
//
// Ports
//   clk            in   rising-edge clock for all logic
//   reset          in   synchronous, active-high
//   word_in        in   [9]=stop, [8:1]=data, [0]=start
//   word_valid     in   word_in valid this cycle
//   rx_byte        out  last accepted data byte (holds between pulses)
//   rx_byte_valid  out  1-cycle pulse, rx_byte/rx_byte_idx updated
//   rx_byte_idx    out  position of rx_byte within the frame
//   frame_data     out  last complete frame, byte k at [8k+7:8k]
//   frame_valid    out  1-cycle pulse, frame_data updated
//   framing_error  out  1-cycle pulse, bad start/stop bit, frame aborted
//   timeout_error  out  1-cycle pulse, gap timeout, frame aborted
//   err_count      out  saturating count of framing + timeout errors
//   busy           out  1 while a partial frame is held
// ---------------------------------------------------------------------------
module frame_receiver_with_sync #(
  parameter int FRAME_BYTES    = 16,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               word_in,
  input  logic                     word_valid,
  output logic [7:0]               rx_byte,
  output logic                     rx_byte_valid,
  output logic [3:0]               rx_byte_idx,
  output logic [8*FRAME_BYTES-1:0] frame_data,
  output logic                     frame_valid,
  output logic                     framing_error,
  output logic                     timeout_error,
  output logic [ERR_CNT_W-1:0]     err_count,
  output logic                     busy
);

  // Gap counter only needs to reach TIMEOUT_CYCLES.
  localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  state_e                         state_q,         state_d;
  logic [3:0]                     cnt_q,           cnt_d;
  logic [GAP_W-1:0]               gap_q,           gap_d;
  logic [FRAME_BYTES-1:0][7:0]    buf_q,           buf_d;
  logic [FRAME_BYTES-1:0][7:0]    frame_q,         frame_d;
  logic [7:0]                     rx_byte_q,       rx_byte_d;
  logic [3:0]                     rx_byte_idx_q,   rx_byte_idx_d;
  logic                           rx_byte_valid_q, rx_byte_valid_d;
  logic                           frame_valid_q,   frame_valid_d;
  logic                           framing_error_q, framing_error_d;
  logic                           timeout_error_q, timeout_error_d;
  logic [ERR_CNT_W-1:0]           err_count_q,     err_count_d;

  logic                           word_good;
  logic [7:0]                     word_data;
  logic [GAP_W-1:0]               gap_inc;
  logic [ERR_CNT_W-1:0]           err_inc;

  assign word_good = (word_in[0] == 1'b0) && (word_in[9] == 1'b1);
  assign word_data = word_in[8:1];
  assign gap_inc   = gap_q + GAP_W'(1);
  // Saturating increment: stays at all-ones instead of wrapping.
  assign err_inc   = (&err_count_q) ? err_count_q : err_count_q + ERR_CNT_W'(1);

  // Next-state and output logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    gap_d           = gap_q;
    buf_d           = buf_q;
    frame_d         = frame_q;
    rx_byte_d       = rx_byte_q;
    rx_byte_idx_d   = rx_byte_idx_q;
    rx_byte_valid_d = 1'b0;
    frame_valid_d   = 1'b0;
    framing_error_d = 1'b0;
    timeout_error_d = 1'b0;
    err_count_d     = err_count_q;

    if (word_valid) begin
      // Any word, good or bad, restarts the gap measurement; this is also what
      // lets a word arriving on the would-be timeout cycle win.
      gap_d = '0;
      if (word_good) begin
        buf_d[cnt_q]    = word_data;
        rx_byte_d       = word_data;
        rx_byte_idx_d   = cnt_q;
        rx_byte_valid_d = 1'b1;
        if (cnt_q == LAST_IDX) begin
          // Publish the buffer including the byte written just above.
          frame_d       = buf_d;
          frame_valid_d = 1'b1;
          cnt_d         = '0;
          state_d       = IDLE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = RECV;
        end
      end else begin
        // Bad word: drop the partial frame and resync on the next good word.
        framing_error_d = 1'b1;
        err_count_d     = err_inc;
        cnt_d           = '0;
        state_d         = IDLE;
      end
    end else if (state_q == RECV && TIMEOUT_CYCLES != 0) begin
      if (gap_inc == GAP_W'(TIMEOUT_CYCLES)) begin
        timeout_error_d = 1'b1;
        err_count_d     = err_inc;
        cnt_d           = '0;
        gap_d           = '0;
        state_d         = IDLE;
      end else begin
        gap_d = gap_inc;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      gap_q           <= '0;
      // NOTE: the working buffer is reset as well, so a frame aborted by reset
      // leaves no stale bytes observable anywhere.
      buf_q           <= '0;
      frame_q         <= '0;
      rx_byte_q       <= '0;
      rx_byte_idx_q   <= '0;
      rx_byte_valid_q <= 1'b0;
      frame_valid_q   <= 1'b0;
      framing_error_q <= 1'b0;
      timeout_error_q <= 1'b0;
      err_count_q     <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      gap_q           <= gap_d;
      buf_q           <= buf_d;
      frame_q         <= frame_d;
      rx_byte_q       <= rx_byte_d;
      rx_byte_idx_q   <= rx_byte_idx_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      frame_valid_q   <= frame_valid_d;
      framing_error_q <= framing_error_d;
      timeout_error_q <= timeout_error_d;
      err_count_q     <= err_count_d;
    end
  end

  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_byte_valid_q;
  assign rx_byte_idx   = rx_byte_idx_q;
  assign frame_data    = frame_q;
  assign frame_valid   = frame_valid_q;
  assign framing_error = framing_error_q;
  assign timeout_error = timeout_error_q;
  assign err_count     = err_count_q;
  assign busy          = (state_q == RECV);

endmodule

// File: tb/tb_frame_receiver_with_sync.sv
module tb_frame_receiver_with_sync;

  logic         clk;
  logic         reset;
  logic [9:0]   word_in;
  logic         word_valid;
  logic [7:0]   rx_byte;
  logic         rx_byte_valid;
  logic [3:0]   rx_byte_idx;
  logic [127:0] frame_data;
  logic         frame_valid;
  logic         framing_error;
  logic         timeout_error;
  logic [7:0]   err_count;
  logic         busy;

  int checks = 0;
  int errors = 0;

  frame_receiver_with_sync #(
    .FRAME_BYTES   (16),
    .TIMEOUT_CYCLES(32),
    .ERR_CNT_W     (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .rx_byte_idx  (rx_byte_idx),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .framing_error(framing_error),
    .timeout_error(timeout_error),
    .err_count    (err_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] good(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  // Drive one cycle of inputs at the falling edge; return 1 time unit after
  // the rising edge so outputs of that edge can be sampled.
  task automatic cycle(input logic v, input logic [9:0] w, input logic r);
    @(negedge clk);
    word_valid = v;
    word_in    = w;
    reset      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pulses_quiet(input string tag);
    check({tag, " rx_byte_valid"}, 128'(rx_byte_valid), 128'd0);
    check({tag, " frame_valid"},   128'(frame_valid),   128'd0);
    check({tag, " framing_error"}, 128'(framing_error), 128'd0);
    check({tag, " timeout_error"}, 128'(timeout_error), 128'd0);
  endtask

  // Send one good byte and check the byte-level response.
  task automatic send_good(input string tag, input logic [7:0] d, input logic [3:0] idx,
                           input logic last);
    cycle(1'b1, good(d), 1'b0);
    check({tag, " rx_byte_valid"}, 128'(rx_byte_valid), 128'd1);
    check({tag, " rx_byte"},       128'(rx_byte),       128'(d));
    check({tag, " rx_byte_idx"},   128'(rx_byte_idx),   128'(idx));
    check({tag, " frame_valid"},   128'(frame_valid),   128'(last));
    check({tag, " busy"},          128'(busy),          128'(!last));
  endtask

  logic [127:0] exp_frame;
  logic [127:0] frame1;

  initial begin
    word_valid = 1'b0;
    word_in    = '0;
    reset      = 1'b1;
    repeat (3) cycle(1'b0, 10'h000, 1'b1);

    // Reset state
    check("rst rx_byte",     128'(rx_byte),     128'd0);
    check("rst rx_byte_idx", 128'(rx_byte_idx), 128'd0);
    check("rst frame_data",  frame_data,        128'd0);
    check("rst err_count",   128'(err_count),   128'd0);
    check("rst busy",        128'(busy),        128'd0);
    pulses_quiet("rst");

    // 1: back-to-back frame 0x00..0x0F
    for (int i = 0; i < 16; i++) send_good("t1", 8'(i), 4'(i), i == 15);
    frame1 = 128'h0F0E0D0C0B0A09080706050403020100;
    check("t1 frame_data", frame_data, frame1);
    check("t1 err_count",  128'(err_count), 128'd0);
    cycle(1'b0, 10'h000, 1'b0);
    pulses_quiet("t1 after");
    check("t1 rx_byte hold", 128'(rx_byte),     128'h0F);
    check("t1 idx hold",     128'(rx_byte_idx), 128'd15);

    // 2: framing error on word 5, then resync
    for (int i = 0; i < 5; i++) send_good("t2 pre", 8'hA0 + 8'(i), 4'(i), 1'b0);
    cycle(1'b1, 10'h000, 1'b0);
    check("t2 framing_error", 128'(framing_error), 128'd1);
    check("t2 timeout_error", 128'(timeout_error), 128'd0);
    check("t2 rx_byte_valid", 128'(rx_byte_valid), 128'd0);
    check("t2 frame_valid",   128'(frame_valid),   128'd0);
    check("t2 err_count",     128'(err_count),     128'd1);
    check("t2 busy",          128'(busy),          128'd0);
    check("t2 frame held",    frame_data,          frame1);
    exp_frame = '0;
    for (int i = 0; i < 16; i++) begin
      send_good("t2 resync", 8'h10 + 8'(i), 4'(i), i == 15);
      exp_frame[8*i +: 8] = 8'h10 + 8'(i);
      if (i == 14) check("t2 frame held late", frame_data, frame1);
    end
    check("t2 frame_data", frame_data, exp_frame);

    // 3a: timeout after 32 idle cycles
    for (int i = 0; i < 3; i++) send_good("t3a", 8'h30 + 8'(i), 4'(i), 1'b0);
    for (int i = 0; i < 31; i++) begin
      cycle(1'b0, 10'h000, 1'b0);
      check("t3a no early timeout", 128'(timeout_error), 128'd0);
      check("t3a busy idle",        128'(busy),          128'd1);
    end
    cycle(1'b0, 10'h000, 1'b0);
    check("t3a timeout_error", 128'(timeout_error), 128'd1);
    check("t3a framing_error", 128'(framing_error), 128'd0);
    check("t3a busy",          128'(busy),          128'd0);
    check("t3a err_count",     128'(err_count),     128'd2);
    cycle(1'b0, 10'h000, 1'b0);
    pulses_quiet("t3a after");
    check("t3a count held", 128'(err_count), 128'd2);

    // 3b: 31-cycle gap does not time out; frame continues at index 3
    exp_frame = '0;
    for (int i = 0; i < 3; i++) begin
      send_good("t3b pre", 8'h40 + 8'(i), 4'(i), 1'b0);
      exp_frame[8*i +: 8] = 8'h40 + 8'(i);
    end
    repeat (31) cycle(1'b0, 10'h000, 1'b0);
    check("t3b gap no timeout", 128'(timeout_error), 128'd0);
    for (int i = 3; i < 16; i++) begin
      send_good("t3b", 8'h40 + 8'(i), 4'(i), i == 15);
      exp_frame[8*i +: 8] = 8'h40 + 8'(i);
    end
    check("t3b frame_data", frame_data,        exp_frame);
    check("t3b err_count",  128'(err_count),   128'd2);

    // 4: reset mid-frame
    for (int i = 0; i < 8; i++) send_good("t4 pre", 8'h50 + 8'(i), 4'(i), 1'b0);
    cycle(1'b1, good(8'hEE), 1'b1);
    check("t4 rx_byte",     128'(rx_byte),     128'd0);
    check("t4 rx_byte_idx", 128'(rx_byte_idx), 128'd0);
    check("t4 frame_data",  frame_data,        128'd0);
    check("t4 err_count",   128'(err_count),   128'd0);
    check("t4 busy",        128'(busy),        128'd0);
    pulses_quiet("t4 rst");
    exp_frame = '0;
    for (int i = 0; i < 16; i++) begin
      send_good("t4 new", 8'h60 + 8'(i), 4'(i), i == 15);
      exp_frame[8*i +: 8] = 8'h60 + 8'(i);
    end
    check("t4 frame_data new", frame_data, exp_frame);

    // 5: 300 bad words saturate err_count at 255; alternate the bad bit
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, (i % 2 == 0) ? 10'h000 : 10'h3FF, 1'b0);
      if (i == 0)   check("t5 first count", 128'(err_count), 128'd1);
      if (i == 254) check("t5 count 255",   128'(err_count), 128'd255);
      if (i == 299) check("t5 framing pulse", 128'(framing_error), 128'd1);
    end
    check("t5 saturated",   128'(err_count), 128'd255);
    check("t5 frame held",  frame_data,      exp_frame);

    // 6: idle pattern while not valid is ignored
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 10'h000, 1'b0);
      if (i == 0 || i == 99) begin
        pulses_quiet("t6");
        check("t6 busy", 128'(busy), 128'd0);
      end
    end
    check("t6 err_count", 128'(err_count), 128'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
